// File: rtl/shacc_pkg.sv
// shacc_pkg: shared constants for the shifter-accumulator array.
// Holds the FSM state encoding, default parameter values and a
// sign-extension helper used by the lane datapath.
package shacc_pkg;

    localparam int N_DEF  = 8;
    localparam int W_DEF  = 32;
    localparam int A_DEF  = 16;
    localparam int CW_DEF = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Sign-extend the low 'width' bits of v to 64 bits.
    function automatic logic [63:0] sign_ext(input logic [63:0] v, input int width);
        logic signed [63:0] t;
        t = $signed(v << (64 - width));
        return t >>> (64 - width);
    endfunction

endpackage

// File: rtl/shacc_lane.sv
// shacc_lane: one lane of the shifter-accumulator.
// Computes the next accumulator value combinationally: load, negated load
// (signed MSB plane) or shift-add. With SHACC_SAT_EN defined the exact sum
// is kept two bits wider than the accumulator and clamped to the signed
// W-bit range, and sat_o flags the clamp; otherwise the sum wraps.
module shacc_lane
    import shacc_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int A = A_DEF
)(
    input  logic [W-1:0] acc_i,
    input  logic [A-1:0] plane_i,
    input  logic         first_i,
    input  logic         neg_i,
`ifdef SHACC_SAT_EN
    output logic         sat_o,
`endif
    output logic [W-1:0] next_o
);

`ifdef SHACC_SAT_EN
    localparam int XW = W + 2;
`else
    localparam int XW = W;
`endif

    logic signed [XW-1:0] acc_x_s;
    logic signed [XW-1:0] plane_x_s;
    logic signed [XW-1:0] sum_s;

    assign acc_x_s   = XW'(sign_ext(64'(acc_i), W));
    assign plane_x_s = XW'(sign_ext(64'(plane_i), A));

    // First plane loads (optionally negated); later planes shift-add.
    always_comb begin
        if (first_i) begin
            if (neg_i) begin
                sum_s = -plane_x_s;
            end else begin
                sum_s = plane_x_s;
            end
        end else begin
            sum_s = acc_x_s + acc_x_s + plane_x_s;
        end
    end

`ifdef SHACC_SAT_EN
    logic [2:0] top_s;
    assign top_s = sum_s[XW-1:W-1];

    // The value fits in W bits only when the top three bits agree.
    always_comb begin
        if ((top_s == 3'b000) || (top_s == 3'b111)) begin
            next_o = sum_s[W-1:0];
            sat_o  = 1'b0;
        end else if (sum_s[XW-1]) begin
            next_o = {1'b1, {(W-1){1'b0}}};
            sat_o  = 1'b1;
        end else begin
            next_o = {1'b0, {(W-1){1'b1}}};
            sat_o  = 1'b1;
        end
    end
`else
    assign next_o = sum_s;
`endif

endmodule

// File: rtl/shacc_array.sv
// shacc_array: N-lane, job-sequenced shifter-accumulator.
// Accumulates nplanes MSB-first bit-plane partial sums per result
// (O = 2*O + I), hands each finished result to a one-deep holding register
// with a valid/ready handshake, and sequences nres results per job.
// Optional feature macro: SHACC_SAT_EN (saturating arithmetic + sticky sat).
module shacc_array
    import shacc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int A  = A_DEF,
    parameter int CW = CW_DEF
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            start,
    input  logic [CW-1:0]   nplanes,
    input  logic [CW-1:0]   nres,
    input  logic            msb_neg,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*A-1:0]  I,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  O,
    output logic            busy,
    output logic            done
`ifdef SHACC_SAT_EN
    ,
    output logic            sat
`endif
);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  pc_q, pc_d;
    logic [CW-1:0]  rc_q, rc_d;
    logic [CW-1:0]  np_q, np_d;
    logic [CW-1:0]  nr_q, nr_d;
    logic           neg_q, neg_d;
    logic [N*W-1:0] acc_q, acc_d;
    logic [N*W-1:0] hold_q, hold_d;
    logic           out_valid_q, out_valid_d;
    logic           done_q, done_d;

    logic [N*W-1:0] next_s;
    logic           first_s;
    logic           last_plane_s;
    logic           last_res_s;
    logic           in_ready_s;
    logic           accept_s;

`ifdef SHACC_SAT_EN
    logic           sat_q, sat_d;
    logic [N-1:0]   lane_sat_s;
`endif

    assign first_s      = (pc_q == {CW{1'b0}});
    assign last_plane_s = (pc_q == (np_q - CW'(1)));
    assign last_res_s   = (rc_q == (nr_q - CW'(1)));
    // The final plane of a result stalls only while the holder is full and not draining.
    assign in_ready_s   = (state_q == ST_RUN) && !(last_plane_s && out_valid_q && !out_ready);
    assign accept_s     = in_valid && in_ready_s;

    for (genvar k = 0; k < N; k++) begin : g_lane
        shacc_lane #(
            .W (W),
            .A (A)
        ) u_lane (
            .acc_i   (acc_q[k*W +: W]),
            .plane_i (I[k*A +: A]),
            .first_i (first_s),
            .neg_i   (neg_q),
`ifdef SHACC_SAT_EN
            .sat_o   (lane_sat_s[k]),
`endif
            .next_o  (next_s[k*W +: W])
        );
    end

    // Next-state logic: FSM, counters, accumulator routing and holder handshake.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rc_d        = rc_q;
        np_d        = np_q;
        nr_d        = nr_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
`ifdef SHACC_SAT_EN
        sat_d       = sat_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (clr) begin
            state_d     = ST_IDLE;
            pc_d        = {CW{1'b0}};
            rc_d        = {CW{1'b0}};
            np_d        = {CW{1'b0}};
            nr_d        = {CW{1'b0}};
            neg_d       = 1'b0;
            acc_d       = {(N*W){1'b0}};
            hold_d      = {(N*W){1'b0}};
            out_valid_d = 1'b0;
`ifdef SHACC_SAT_EN
            sat_d       = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        np_d  = (nplanes == {CW{1'b0}}) ? CW'(1) : nplanes;
                        nr_d  = nres;
                        neg_d = msb_neg;
                        pc_d  = {CW{1'b0}};
                        rc_d  = {CW{1'b0}};
`ifdef SHACC_SAT_EN
                        sat_d = 1'b0;
`endif
                        state_d = (nres == {CW{1'b0}}) ? ST_FLUSH : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
`ifdef SHACC_SAT_EN
                        sat_d = sat_q | (|lane_sat_s);
`endif
                        if (last_plane_s) begin
                            hold_d      = next_s;
                            out_valid_d = 1'b1;
                            pc_d        = {CW{1'b0}};
                            rc_d        = rc_q + CW'(1);
                            state_d     = last_res_s ? ST_FLUSH : ST_RUN;
                        end else begin
                            acc_d = next_s;
                            pc_d  = pc_q + CW'(1);
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (!out_valid_q || out_ready) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= {CW{1'b0}};
            rc_q        <= {CW{1'b0}};
            np_q        <= {CW{1'b0}};
            nr_q        <= {CW{1'b0}};
            neg_q       <= 1'b0;
            acc_q       <= {(N*W){1'b0}};
            hold_q      <= {(N*W){1'b0}};
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SHACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rc_q        <= rc_d;
            np_q        <= np_d;
            nr_q        <= nr_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SHACC_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign O         = hold_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
`ifdef SHACC_SAT_EN
    assign sat       = sat_q;
`endif

endmodule

// File: tb/tb_shacc_array.sv
// tb_shacc_array: randomized scoreboard bench for shacc_array.
// Expected results come from a weighted-sum reference model and are queued
// at issue time; a monitor pops and compares on every output handshake.
module tb_shacc_array;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int A  = 8;
    localparam int CW = 6;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    logic           clk = 1'b0;
    logic           rst_n, clr, start, msb_neg, in_valid, out_ready;
    logic [CW-1:0]  nplanes, nres;
    logic [N*A-1:0] I;
    logic [N*W-1:0] O;
    logic           in_ready, out_valid, busy, done;
`ifdef SHACC_SAT_EN
    logic           sat;
`endif

    always #5 clk = ~clk;

    shacc_array #(.N(N), .W(W), .A(A), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .start     (start),
        .nplanes   (nplanes),
        .nres      (nres),
        .msb_neg   (msb_neg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I         (I),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .O         (O),
        .busy      (busy),
        .done      (done)
`ifdef SHACC_SAT_EN
        ,
        .sat       (sat)
`endif
    );

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [N*W-1:0] exp_q[$];
    logic [N*W-1:0] last_out;
    int             or_mode = 1;   // 0 random, 1 high, 2 low
    int             ov_seen = 0;
    int             done_cnt = 0;
    bit             sat_exp;
    logic [N*A-1:0] pl[64];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact weighted sum of planes, wrapped or step-wise clamped.
    function automatic logic [W-1:0] ref_lane(input int k, input int np, input bit neg);
        longint v;
        longint x;
        logic [A-1:0] b;
        v = 0;
        for (int j = 0; j < np; j++) begin
            b = pl[j][k*A +: A];
            x = longint'($signed(b));
`ifdef SHACC_SAT_EN
            if (j == 0) v = neg ? -x : x;
            else        v = 2 * v + x;
            if (v > MAXV) begin v = MAXV; sat_exp = 1'b1; end
            if (v < MINV) begin v = MINV; sat_exp = 1'b1; end
`else
            v += ((j == 0 && neg) ? -x : x) * (longint'(1) << (np - 1 - j));
`endif
        end
        return v[W-1:0];
    endfunction

    task automatic gen_result(input int np, input bit neg, input int mode);
        logic [N*W-1:0] e;
        for (int j = 0; j < np; j++) begin
            pl[j] = (N*A)'($urandom);
            if (mode == 1) pl[j][A-1:0] = (j == 1) ? A'(0) : A'(1);
            else if (mode == 2) pl[j] = {N{A'(100)}};
        end
        for (int k = 0; k < N; k++) e[k*W +: W] = ref_lane(k, np, neg);
        exp_q.push_back(e);
    endtask

    task automatic drive_plane(input logic [N*A-1:0] d);
        int g;
        g = 0;
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            I = (N*A)'($urandom);
        end
        while (1) begin
            @(negedge clk);
            in_valid = 1'b1;
            I = d;
            #1;
            if (in_ready) break;
            g++;
            if (g > 300) begin
                n_cmp++; n_bad++;
                $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", g);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 500) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (done) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL done_timeout: no done within %0d cycles", lat);
    endtask

    task automatic do_start(input int np, input int nr, input bit neg);
        @(negedge clk);
        start = 1'b1; nplanes = CW'(np); nres = CW'(nr); msb_neg = neg; in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, (nr != 0) ? 1 : 0);
    endtask

    task automatic run_job(input int np, input int nr, input bit neg, input int mode, output int lat);
        int npe;
        npe = (np == 0) ? 1 : np;
        sat_exp = 1'b0;
        do_start(np, nr, neg);
        for (int r = 0; r < nr; r++) begin
            gen_result(npe, neg, mode);
            for (int j = 0; j < npe; j++) drive_plane(pl[j]);
        end
        wait_done(lat);
        check("queue_empty_at_done", exp_q.size(), 0);
`ifdef SHACC_SAT_EN
        check("sat_flag", sat, sat_exp);
`endif
    endtask

    // Monitor: drives out_ready, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        logic [N*W-1:0] e;
        case (or_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        if (out_valid) ov_seen++;
        if (done) begin
            done_cnt++;
            check("busy_low_with_done", busy, 0);
        end
        if (rst_n && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out_unexpected: got %h with no result pending", O);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (O !== e) begin
                    n_bad++;
                    $display("FAIL out_data: got %h expected %h", O, e);
                end
                last_out = O;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; msb_neg = 1'b0; in_valid = 1'b0;
        nplanes = '0; nres = '0; I = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_O", O, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 1,0,1 on lane0 -> 5; done two cycles after final plane.
        or_mode = 1;
        run_job(3, 1, 1'b0, 1, lat);
        check("lane0_unsigned", last_out[W-1:0], 5);
        check("done_latency", lat, 2);

        // Signed: -4 + 0 + 1 = -3.
        run_job(3, 1, 1'b1, 1, lat);
        check("lane0_signed", last_out[W-1:0], 16'hFFFD);

        // Stall on final plane of second result while holder is full.
        or_mode = 2;
        do_start(2, 3, 1'b0);
        gen_result(2, 1'b0, 0);
        drive_plane(pl[0]);
        drive_plane(pl[1]);
        gen_result(2, 1'b0, 0);
        drive_plane(pl[0]);
        @(negedge clk);
        in_valid = 1'b1; I = pl[1];
        #1;
        check("stall_in_ready", in_ready, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_hold_valid", out_valid, 1);
            check("stall_in_ready_hold", in_ready, 0);
        end
        or_mode = 1;
        drive_plane(pl[1]);
        #1;
        check("load_drain_valid", out_valid, 1);
        gen_result(2, 1'b0, 0);
        drive_plane(pl[0]);
        drive_plane(pl[1]);
        wait_done(lat);
        check("stall_queue_empty", exp_q.size(), 0);

        // Overflow: twelve planes of +100.
        run_job(12, 1, 1'b0, 2, lat);
`ifdef SHACC_SAT_EN
        check("ovf_lane0", last_out[W-1:0], 32767);
`else
        check("ovf_lane0", last_out[W-1:0], 16284);
`endif

        // clr mid-job with a pending result.
        or_mode = 2;
        do_start(2, 2, 1'b0);
        gen_result(2, 1'b0, 0);
        drive_plane(pl[0]);
        drive_plane(pl[1]);
        #1;
        check("pre_clr_valid", out_valid, 1);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_q.delete();
        check("clr_out_valid", out_valid, 0);
        check("clr_O", O, 0);
        check("clr_busy", busy, 0);
        check("clr_in_ready", in_ready, 0);
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        check("clr_no_done", done_cnt - d0, 0);
        or_mode = 0;
        run_job(4, 2, 1'b1, 0, lat);

        // nres = 0: done two cycles after start, never out_valid.
        do_start(3, 0, 1'b0);
        ov_seen = 0;
        wait_done(lat);
        check("nres0_done_latency", lat, 2);
        check("nres0_no_valid", ov_seen, 0);

        // start during RUN is ignored.
        or_mode = 0;
        sat_exp = 1'b0;
        do_start(3, 2, 1'b1);
        gen_result(3, 1'b1, 0);
        drive_plane(pl[0]);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1; nplanes = CW'(5); nres = CW'(1); msb_neg = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_plane(pl[1]);
        drive_plane(pl[2]);
        gen_result(3, 1'b1, 0);
        for (int j = 0; j < 3; j++) drive_plane(pl[j]);
        wait_done(lat);
        check("ignored_start_queue_empty", exp_q.size(), 0);

        // Randomized jobs.
        for (int t = 0; t < 20; t++) begin
            or_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_job($urandom_range(0, 6), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shacc_array.md
# shacc_array

Multi-lane, job-sequenced shifter-accumulator for the MVU datapath. It takes N lanes of bit-plane partial sums, MSB-first. For each result it accumulates `nplanes` planes as O = 2·O + I, and can optionally give the MSB plane a negative weight for signed operands. Finished results go to a one-deep holding register with a valid/ready handshake, so the next result accumulates while the downstream consumer is busy.

## Interface
- `N`, 8, number of lanes.
- `W`, 32, accumulator and output width per lane (signed).
- `A`, 16, input partial-sum width per lane (signed, A ≤ W).
- `CW`, 6, width of the plane and result counters.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous abort; same effect as reset, one cycle.
- `start` input 1: job start pulse; sampled only in IDLE.
- `nplanes` input CW: planes per result; latched on start; 0 is treated as 1.
- `nres` input CW: results per job; latched on start.
- `msb_neg` input 1: first plane of each result is subtracted; latched on start.
- `in_valid` input 1: plane data valid.
- `in_ready` output 1: plane data accepted when in_valid && in_ready.
- `I` input N·A: lane k in bits [k·A +: A], signed.
- `out_valid` output 1: holding register holds a result.
- `out_ready` input 1: consumer accepts the result.
- `O` output N·W: lane k in bits [k·W +: W], signed.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse at the end of a job.

## Operation
- States:
  - IDLE: start → RUN, or → FLUSH if nres = 0.
  - RUN: after the last plane of the last result is accepted → FLUSH.
  - FLUSH: when the holding register is empty or being accepted this cycle → IDLE with done = 1.
- Plane counter `pc` and result counter `rc` are cleared on start.
- On each accepted plane, per lane (I sign-extended to W):
  - `pc` = 0: acc = msb_neg ? −I : I. This loads; no previous value is kept.
  - `pc` > 0: acc = acc + acc + I.
- When `pc` = nplanes−1, the updated value goes to the holding register instead of acc. Then out_valid is set, `pc` returns to 0 and `rc` increments.
- in_ready = (state == RUN) && !(pc == nplanes−1 && out_valid && !out_ready).
  - The stall applies only to the final plane of a result, and only while the holder is occupied and not being drained.
- Holding register load and drain in the same cycle: the new result replaces the old one and out_valid stays 1.
- Arithmetic is W-bit two's complement; overflow behaviour is set by the Configuration section.
- start while busy is ignored. in_valid outside RUN is ignored.
- clr or reset mid-job:
  - counters, acc and holding register go to 0, out_valid = 0, state = IDLE;
  - no done pulse;
  - a pending result is discarded.

## Timing
- Reset values: O = 0, out_valid = 0, in_ready = 0, busy = 0, done = 0, all acc = 0, state IDLE.
- Start to in_ready high: 1 cycle (RUN is entered on the start edge).
- Final plane accepted at edge t → O and out_valid valid after edge t; no extra pipeline stage.
- Throughput is one plane per cycle with no stalls when out_ready stays high.
- done asserts for one cycle in the cycle after the FLUSH exit condition is met; busy falls in that same cycle.
- Last output handshake on edge t → IDLE after edge t, done = 1 during cycle t+1.
- nres = 0 → done 2 cycles after start, with no out_valid.

## Configuration
- `SHACC_SAT_EN` defined: every acc update and the holder load clamp to [−2^(W−1), 2^(W−1)−1].
  - Saturation is detected from the (W+2)-bit exact sum.
  - A sticky per-job output `sat` (1 bit, reset 0, cleared on start) is added and set on any clamp.
- Not defined: results wrap modulo 2^W and the `sat` port does not exist.

## Structure
- Package `shacc_pkg` holds:
  - state enum (IDLE, RUN, FLUSH);
  - default parameter constants;
  - a sign-extend helper function.
- Sub-module `shacc_lane` (parameters W, A) is instantiated N times in a generate loop.
  - It implements the load / negate-load / shift-add datapath and the optional saturation for one lane.
  - It exposes the next value combinationally so the top level routes it to acc or to the holder.
- The FSM, counters and handshake live in the top level.

## Test plan
- N=2, nplanes=3, nres=1, msb_neg=0, lane0 planes 1,0,1 → O lane0 = 5 one cycle after the third plane; done follows.
- Same stimulus with msb_neg=1 → lane0 = −4+0+1 = −3 (0xFFFFFFFD).
- nres=3, nplanes=2, out_ready held low → second result stalls with in_ready low on its final plane. Raising out_ready drains the results in order with no loss or duplication.
- W=8, repeated planes of +100 → with `SHACC_SAT_EN` O = 127 and sat = 1; without it the result is the wrapped value.
- clr asserted mid-RUN with out_valid=1 → next cycle out_valid=0, O=0, busy=0, no done. A new start runs normally.
- nres=0 start → done pulse after 2 cycles, out_valid never asserted; start pulsed during RUN → ignored, with counts unchanged.
